fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   IF stage of the 5-stage MIPS pipeline: owns the architectural PC, issues instruction-memory
//   requests over a req/ack handshake, and loads the IF/ID register consumed by decode and the
//   next-PC unit. Accepts taken branch/jump targets from the ID-stage next-PC unit. The delay
//   slot is always fetched. Also accepts an exception/ERET flush from the CP0 path.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC loaded on reset
//   NOP_INSTR   32'h0000_0000  instr driven into IF/ID on a bubble
// PORTS
//   clk          in   1   rising-edge clock, the block's only clock
//   reset        in   1   synchronous, active-high reset
//   id_stall     in   1   hazard unit: hold IF/ID and PC this cycle
//   redirect     in   1   ID: taken branch/jump (pre-qualified by !id_stall, one-cycle pulse)
//   redirect_pc  in   32  ID: target from next-PC unit; bits[1:0] ignored (forced 00)
//   flush        in   1   CP0: exception/ERET; kill IF/ID and in-flight fetch
//   flush_pc     in   32  CP0: handler / EPC target; bits[1:0] ignored
//   imem_req     out  1   fetch request; held high until imem_ack
//   imem_addr    out  32  word address = pc; stable while imem_req high
//   imem_ack     in   1   data valid this cycle; 1..N cycle latency
//   imem_rdata   in   32  instruction word, valid with imem_ack
//   pc           out  32  current fetch PC
//   if_id_instr  out  32  IF/ID instruction
//   if_id_pc     out  32  IF/ID instruction address (ID computes PC+4 / PC+8 from it)
//   if_id_valid  out  1   IF/ID holds a real instruction
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0,
//     pend_redir=0, pend_flush=0, kill=0, imem_req=0 in reset cycle, 1 the cycle after.
//   FSM (2 states, registered):
//     FETCH: imem_req=1, imem_addr=pc.
//       ack & !kill & !id_stall -> IF/ID<={rdata,pc,1}; pc<=next_pc; stay FETCH.
//       ack & !kill & id_stall  -> hold_buf<=rdata; IF/ID unchanged; -> HELD.
//       ack & kill              -> data dropped; pc<=flush target; kill<=0; stay FETCH.
//       no ack: id_stall ? IF/ID hold : IF/ID<=bubble (valid=0, instr=NOP_INSTR).
//     HELD: imem_req=0. !id_stall -> IF/ID<={hold_buf,pc,1}; pc<=next_pc; -> FETCH.
//   Delivery to IF/ID: ack & !kill & !id_stall in FETCH, or !id_stall in HELD (always valid=1).
//   next_pc (applied only on a delivery): pend_redir ? redir_tgt : pc+4, pc+4 wrapping mod 2^32.
//     If redirect arrives the same cycle as the delivery, redirect_pc is used directly.
//     The delivered instruction is the delay slot; pend_redir clears on that delivery.
//   redirect when no delivery that cycle: redir_tgt<=redirect_pc, pend_redir<=1.
//   flush (highest priority, overrides id_stall and redirect):
//     IF/ID<=bubble; pend_redir<=0; state->FETCH;
//     FETCH with req outstanding and no ack this cycle: kill<=1, flush target latched;
//       request stays high to same addr until ack (handshake has no abort).
//     FETCH with ack this cycle, or HELD, or reset-release cycle: pc<=flush_pc immediately.
//     Second flush while kill=1: latched target updated, kill stays set.
//   Reset mid-fetch: imem_req drops; imem ignores an unacked request when req falls.
//   Invariant: at most one imem request outstanding; imem_addr never changes while req=1 & !ack.
// STRUCTURE
//   Shared package mips_pkg: RESET_PC, NOP_INSTR, fetch state encoding (FETCH, HELD).
//   One sub-module: fetch_pc_sel, a combinational next-PC/flush-target mux.
//   All registers live in fetch_stage.
// TESTING
//   1 reset, zero-wait ack every cycle -> pc 3000,3004,3008; if_id_valid rises 1 cycle after first ack.
//   2 ack latency 3, no stall -> imem_addr held 3 cycles; 2 bubbles (valid=0) between instrs.
//   3 branch at 3000 redirect 3100 with delivery of 3004 -> IF/ID 3004 (delay slot), then fetch 3100.
//   4 redirect 3100 while 3004 fetch waiting 2 cycles -> 3004 delivered, next imem_addr 3100.
//   5 id_stall high 4 cycles over an ack -> HELD, req=0, IF/ID unchanged; release -> hold_buf delivered.
//   6 flush 4180 mid-fetch (no ack) -> req held to old addr, ack data dropped, next imem_addr 4180.
//   7 flush in HELD -> bubble, next imem_addr = flush_pc.
//   8 reset asserted mid-fetch -> imem_req drops, pc=3000.
//   9 pc at FFFF_FFFC delivered -> pc wraps to 0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset vector, bubble encoding,
// fetch FSM state encoding and a word-alignment helper.
package mips_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      HELD  = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection for a delivery, plus aligned redirect/flush targets.
module fetch_pc_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        pend_redir_i,
   input  logic [31:0] redir_tgt_i,
   input  logic [31:0] flush_pc_i,
   output logic [31:0] next_pc_o,
   output logic [31:0] redir_tgt_o,
   output logic [31:0] flush_tgt_o
);

   logic [31:0] pc_plus4_s;

   assign pc_plus4_s  = pc_i + 32'd4;
   assign redir_tgt_o = word_align(redirect_pc_i);
   assign flush_tgt_o = word_align(flush_pc_i);

   // A same-cycle redirect beats a pending one; sequential fetch otherwise.
   always_comb begin
      next_pc_o = pc_plus4_s;
      if (redirect_i) begin
         next_pc_o = redir_tgt_o;
      end else if (pend_redir_i) begin
         next_pc_o = redir_tgt_i;
      end else begin
         next_pc_o = pc_plus4_s;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs the imem req/ack handshake and loads IF/ID,
// honouring stalls, delayed-branch redirects and CP0 flushes.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_stall,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   input  logic                 flush,
   input  logic [31:0]          flush_pc,
   fetch_stage_if.master        imem,
   output logic [31:0]          pc,
   output logic [31:0]          if_id_instr,
   output logic [31:0]          if_id_pc,
   output logic                 if_id_valid
);

   fetch_state_e state_q, state_d;
   logic         req_q, req_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic [31:0]  ifid_pc_q, ifid_pc_d;
   logic         ifid_valid_q, ifid_valid_d;
   logic [31:0]  hold_buf_q, hold_buf_d;
   logic         pend_redir_q, pend_redir_d;
   logic [31:0]  redir_tgt_q, redir_tgt_d;
   logic         kill_q, kill_d;
   logic [31:0]  kill_tgt_q, kill_tgt_d;

   logic         ack_v_s;
   logic         deliver_s;
   logic [31:0]  word_s;
   logic [31:0]  next_pc_s;
   logic [31:0]  redir_tgt_s;
   logic [31:0]  flush_tgt_s;

   fetch_pc_sel u_pc_sel (
      .pc_i          (pc_q),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .pend_redir_i  (pend_redir_q),
      .redir_tgt_i   (redir_tgt_q),
      .flush_pc_i    (flush_pc),
      .next_pc_o     (next_pc_s),
      .redir_tgt_o   (redir_tgt_s),
      .flush_tgt_o   (flush_tgt_s)
   );

   // An ack only counts while our request is actually on the bus.
   assign ack_v_s   = imem.ack & req_q;
   assign word_s    = (state_q == HELD) ? hold_buf_q : imem.rdata;
   assign deliver_s = ~flush & ~id_stall &
                      (((state_q == FETCH) & ack_v_s & ~kill_q) | (state_q == HELD));

   // Next-state and IF/ID load logic.
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      hold_buf_d   = hold_buf_q;
      pend_redir_d = pend_redir_q;
      redir_tgt_d  = redir_tgt_q;
      kill_d       = kill_q;
      kill_tgt_d   = kill_tgt_q;

      if (flush) begin
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
         pend_redir_d = 1'b0;
         state_d      = FETCH;
         req_d        = 1'b1;
         // The handshake cannot be aborted, so an unanswered request is drained first.
         if (req_q && !ack_v_s) begin
            kill_d     = 1'b1;
            kill_tgt_d = flush_tgt_s;
         end else begin
            pc_d   = flush_tgt_s;
            kill_d = 1'b0;
         end
      end else if (deliver_s) begin
         ifid_instr_d = word_s;
         ifid_pc_d    = pc_q;
         ifid_valid_d = 1'b1;
         pc_d         = next_pc_s;
         pend_redir_d = 1'b0;
         state_d      = FETCH;
         req_d        = 1'b1;
      end else begin
         case (state_q)
            FETCH: begin
               if (ack_v_s && !kill_q) begin
                  hold_buf_d = imem.rdata;
                  state_d    = HELD;
                  req_d      = 1'b0;
               end else begin
                  if (ack_v_s) begin
                     pc_d   = kill_tgt_q;
                     kill_d = 1'b0;
                  end else begin
                     kill_d = kill_q;
                  end
                  req_d = 1'b1;
                  if (!id_stall) begin
                     ifid_instr_d = NOP_INSTR;
                     ifid_valid_d = 1'b0;
                  end else begin
                     ifid_valid_d = ifid_valid_q;
                  end
               end
            end
            HELD: begin
               req_d = 1'b0;
            end
            default: begin
               state_d = FETCH;
               req_d   = 1'b0;
            end
         endcase
         if (redirect) begin
            pend_redir_d = 1'b1;
            redir_tgt_d  = redir_tgt_s;
         end else begin
            pend_redir_d = pend_redir_q;
         end
      end
   end

   // State and pipeline register update.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= FETCH;
         req_q        <= 1'b0;
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= 32'h0000_0000;
         ifid_valid_q <= 1'b0;
         hold_buf_q   <= 32'h0000_0000;
         pend_redir_q <= 1'b0;
         redir_tgt_q  <= 32'h0000_0000;
         kill_q       <= 1'b0;
         kill_tgt_q   <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         hold_buf_q   <= hold_buf_d;
         pend_redir_q <= pend_redir_d;
         redir_tgt_q  <= redir_tgt_d;
         kill_q       <= kill_d;
         kill_tgt_q   <= kill_tgt_d;
      end
   end

   assign imem.req    = req_q;
   assign imem.addr   = pc_q;
   assign pc          = pc_q;
   assign if_id_instr = ifid_instr_q;
   assign if_id_pc    = ifid_pc_q;
   assign if_id_valid = ifid_valid_q;

endmodule
